// File: rtl/circle_path_ctrl_pkg.sv
// Shared constants and helpers for the rotating-circle animation controller.
package circle_pkg;

   localparam logic ROW_TOP    = 1'b1;
   localparam logic ROW_BOTTOM = 1'b0;

   // Digit index and row that a perimeter position lights up.
   typedef struct packed {
      logic [31:0] idx;
      logic        row;
   } pos_map_t;

   // Bits needed to hold a perimeter position 0 .. 2*n-1.
   function automatic int pos_width(input int n);
      return $clog2(2 * n);
   endfunction

   // Positions 0..n-1 walk the top row left to right (leftmost digit is n-1);
   // positions n..2n-1 walk the bottom row right to left.
   function automatic pos_map_t pos_map(input logic [31:0] p, input logic [31:0] n);
      pos_map_t m;
      if (p < n) begin
         m.idx = n - 32'd1 - p;
         m.row = ROW_TOP;
      end else begin
         m.idx = p - n;
         m.row = ROW_BOTTOM;
      end
      return m;
   endfunction

endpackage

// File: rtl/circle_path_ctrl_if.sv
// Control and display-drive signals between the animation controller and its user.
interface circle_path_if
   import circle_pkg::*;
#(
   parameter int NUM_DIGITS = 4
);
   localparam int PW = pos_width(NUM_DIGITS);

   logic                  run;
   logic                  cw;
   logic                  clear;
   logic [NUM_DIGITS-1:0] digit_en;
   logic [NUM_DIGITS-1:0] digit_row;
   logic [PW-1:0]         pos;
   logic                  step;

   // Controlling side: issues run/direction/clear, observes the display drive.
   modport master (
      output run, cw, clear,
      input  digit_en, digit_row, pos, step
   );

   // Controller side.
   modport slave (
      input  run, cw, clear,
      output digit_en, digit_row, pos, step
   );
endinterface

// File: rtl/circle_path_ctrl_tick_prescaler.sv
// Divides the system clock into one-cycle animation ticks; freezes while run is low.
module tick_prescaler #(
   parameter int TICK_DIV = 25_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic clear,
   output logic tick
);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Tick is the last count of a running cycle; TICK_DIV=1 keeps count at 0 so every run cycle ticks.
   assign tick = run && (count_q == LAST);

   // Next count: clear wins, otherwise count while running and wrap after the last value.
   always_comb begin
      count_d = count_q;
      if (clear)
         count_d = '0;
      else if (run)
         count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n)
         count_q <= '0;
      else
         count_q <= count_d;
   end
endmodule

// File: rtl/circle_path_ctrl.sv
// Moves a single lit circle around the display perimeter, one position per tick.
module circle_path_ctrl
   import circle_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int TICK_DIV   = 25_000_000
) (
   input  logic         clk,
   input  logic         rst_n,
   circle_path_if.slave bus
);
   localparam int PW = pos_width(NUM_DIGITS);
   localparam logic [PW-1:0]         POS_LAST = PW'(2 * NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] EN_HOME  = NUM_DIGITS'(1) << (NUM_DIGITS - 1);

   logic                  tick;
   logic [PW-1:0]         pos_q, pos_d;
   logic [NUM_DIGITS-1:0] en_q, en_d;
   logic [NUM_DIGITS-1:0] row_q, row_d;
   logic                  step_q;
   pos_map_t              map_d;

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (bus.run),
      .clear (bus.clear),
      .tick  (tick)
   );

   // Next position from the direction sampled on this tick, and its display decode.
   always_comb begin
      if (bus.cw)
         pos_d = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
      else
         pos_d = (pos_q == '0) ? POS_LAST : pos_q - PW'(1);
      map_d = pos_map(32'(pos_d), 32'(NUM_DIGITS));
      en_d  = NUM_DIGITS'(1) << map_d.idx;
      row_d = {NUM_DIGITS{map_d.row}};
   end

   // Position, decoded outputs and step pulse; clear overrides a coincident tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_q  <= '0;
         en_q   <= EN_HOME;
         row_q  <= {NUM_DIGITS{ROW_TOP}};
         step_q <= 1'b0;
      end else if (bus.clear) begin
         pos_q  <= '0;
         en_q   <= EN_HOME;
         row_q  <= {NUM_DIGITS{ROW_TOP}};
         step_q <= 1'b0;
      end else if (tick) begin
         pos_q  <= pos_d;
         en_q   <= en_d;
         row_q  <= row_d;
         step_q <= 1'b1;
      end else begin
         step_q <= 1'b0;
      end
   end

   assign bus.pos       = pos_q;
   assign bus.digit_en  = en_q;
   assign bus.digit_row = row_q;
   assign bus.step      = step_q;
endmodule

// File: doc/circle_path_ctrl.md
# circle_path_ctrl

Animation controller for the rotating-circle effect on a multi-digit seven-segment display. It sits directly upstream of the per-digit circle renderers. It advances a single lit "circle" around the display perimeter at a fixed step rate:

- left to right along the top row, then right to left along the bottom row (clockwise), or the reverse.

Each cycle it drives one enable bit and one row bit per digit, which the renderers turn into segment patterns.

## Interface

Parameters:
- NUM_DIGITS, 4, number of display digits; legal range ≥ 2. Digit index NUM_DIGITS-1 is leftmost, index 0 is rightmost.
- TICK_DIV, 25_000_000, clock cycles per animation step; legal range ≥ 1.

Ports:
- clk  input  1  system clock; single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- run  input  1  1 = prescaler counts and the animation advances; 0 = everything freezes.
- cw  input  1  direction: 1 = clockwise (position increments), 0 = counter-clockwise (position decrements).
- clear  input  1  synchronous return to position 0 and prescaler 0.
- digit_en  output  NUM_DIGITS  one-hot; the bit of the digit showing the circle.
- digit_row  output  NUM_DIGITS  row per digit, 1 = top circle, 0 = bottom circle. All bits equal the current row.
- pos  output  $clog2(2*NUM_DIGITS)  current perimeter position, 0 .. 2*NUM_DIGITS-1.
- step  output  1  one-cycle pulse, high in the first cycle a new position is visible.

## Operation

- Position map (P = pos, N = NUM_DIGITS):
  - P < N: row = top, digit index N-1-P.
  - P ≥ N: row = bottom, digit index P-N.
- The map is therefore:
  - P=0: top of the leftmost digit.
  - P=N-1: top of the rightmost digit.
  - P=N: bottom of the rightmost digit.
  - P=2N-1: bottom of the leftmost digit.
- Prescaler:
  - counts 0 .. TICK_DIV-1 while run=1 and wraps to 0;
  - a tick occurs in a cycle where run=1 and the count = TICK_DIV-1;
  - with TICK_DIV=1, every run cycle is a tick.
- On a tick:
  - cw=1: pos ← (pos = 2N-1) ? 0 : pos+1.
  - cw=0: pos ← (pos = 0) ? 2N-1 : pos-1.
- run=0: the prescaler count, pos and outputs hold; step = 0.
- clear=1: prescaler ← 0, pos ← 0, step ← 0 at the next edge, regardless of run or a coincident tick. clear has priority over the tick.
- cw is sampled only on tick cycles. A change between ticks affects only the next step.
- digit_en is always exactly one-hot; digit_row is uniform. Each downstream renderer i receives enable = digit_en[i] and row = digit_row[i].

## Timing

- Reset values (asynchronous, while rst_n=0):
  - prescaler = 0, pos = 0, step = 0;
  - digit_en = only bit N-1 set; digit_row = all ones.
- After rst_n deasserts with run=1 and clear=0, the first tick is in cycle TICK_DIV-1 (counting the first post-reset edge as cycle 0). pos, digit_en, digit_row and step update at the edge ending that cycle.
- All outputs are registered:
  - digit_en and digit_row are decoded from next-pos, so they change on the same edge as pos;
  - there is no combinational path from any input to any output.
- step is high for exactly the one cycle following each position update. It is not asserted on clear or reset.
- Steady step period is TICK_DIV cycles while run=1. Pausing run for k cycles stretches that interval by exactly k.
- Reset asserted mid-step discards the partial prescaler count. Behaviour after release is identical to power-up.

## Structure

- Package circle_pkg:
  - ROW_TOP = 1'b1, ROW_BOTTOM = 1'b0;
  - a function returning the position width for a given digit count;
  - a function mapping (pos, N) to the digit index and row.
- Sub-module tick_prescaler:
  - parameter TICK_DIV; inputs clk, rst_n, run, clear; output tick;
  - mod-TICK_DIV counter with hold and synchronous clear.
- The top level holds the position register, the direction logic, the output decode registers and the step register.

## Test plan

All scenarios use N=4 and TICK_DIV=3.

- **Reset check:** assert rst_n=0 mid-run → outputs immediately show pos=0, digit_en=4'b1000, digit_row=4'b1111, step=0.
- **Clockwise lap:** run=1, cw=1 for 24 cycles →
  - pos sequence 1,2,…,7,0;
  - one step pulse every 3 cycles;
  - at pos=4: digit_en=0001, row=0;
  - at pos=7: digit_en=1000, row=0.
- **Counter-clockwise wrap:** from pos=0 with cw=0 → next pos=7, digit_en=1000, digit_row=0000.
- **Pause:** drop run for 5 cycles at prescaler count 1 → pos and outputs hold; the next step arrives 3+5 cycles after the previous one.
- **Clear priority:** clear=1 in a tick cycle at pos=5 → pos=0, digit_en=1000, no step pulse; the next step is 3 cycles after clear deasserts.
- **Direction change between ticks:** toggle cw at count 0 → the next step uses the new direction. Check digit_en stays one-hot throughout.
